// File: rtl/nios2_onchip_ram_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM.
// Holds the controller state encoding and width helpers.
package nios2_onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    // Never returns 0 so a single-word RAM still gets a 1-bit address.
    function automatic int ram_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ram_be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/nios2_onchip_ram_rdpipe.sv
// Per-port read return path: valid pipeline, optional output
// register and zeroing of out-of-range reads.
module nios2_onchip_ram_rdpipe
    import nios2_onchip_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_i,
    input  logic              oor_i,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic [DATA_W-1:0] readdata_o,
    output logic              readdatavalid_o
);

    logic              v1_q;
    logic              z1_q;
    logic [DATA_W-1:0] rdata_d;

    // z1_q resets high so readdata reads 0 before the first read.
    assign rdata_d = z1_q ? '0 : ram_q_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            z1_q <= 1'b1;
        end else begin
            v1_q <= rd_i;
            if (rd_i) begin
                z1_q <= oor_i;
            end
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic              v2_q;
            logic [DATA_W-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_q    <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rdata_q <= rdata_d;
                    end
                end
            end

            assign readdata_o      = rdata_q;
            assign readdatavalid_o = v2_q & ~reset;
        end else begin : g_lat1
            assign readdata_o      = rdata_d;
            assign readdatavalid_o = v1_q & ~reset;
        end
    endgenerate

endmodule

// File: rtl/nios2_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM with byte enables, pipelined
// reads and an optional zero sweep after reset.
module nios2_onchip_ram_dp
    import nios2_onchip_ram_pkg::*;
#(
    parameter int    DATA_W         = 32,
    parameter int    DEPTH          = 10240,
    parameter int    AW             = ram_clog2(DEPTH),
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         s1_address,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [AW-1:0]         s2_address,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);

    localparam int            BE_W    = ram_be_w(DATA_W);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    ram_state_e    state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic          clearing;
    logic          busy;

    assign clearing = (state_q == ST_CLEAR);
    assign busy     = reset | clearing;
    assign ptr_d    = ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ptr_q   <= '0;
        end else if (clearing) begin
            ptr_q <= ptr_d;
            if (ptr_q == LAST_A) begin
                state_q <= ST_READY;
            end
        end
    end

    logic acc1, acc2, wr1, wr2, rd1, rd2, in1, in2;

    assign acc1 = s1_chipselect & (s1_read | s1_write) & ~busy;
    assign acc2 = s2_chipselect & (s2_read | s2_write) & ~busy;
    assign wr1  = acc1 & s1_write;
    assign wr2  = acc2 & s2_write;
    assign rd1  = acc1 & ~s1_write;
    assign rd2  = acc2 & ~s2_write;
    assign in1  = ({1'b0, s1_address} < DEPTH_L);
    assign in2  = ({1'b0, s2_address} < DEPTH_L);

    // The clear sweep borrows port A; s1 owns it otherwise.
    logic              a_we;
    logic [AW-1:0]     a_addr;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] a_wd;
    logic              b_we;

    assign a_we   = (clearing & ~reset) | (wr1 & in1);
    assign a_addr = clearing ? ptr_q : s1_address;
    assign a_be   = clearing ? '1 : s1_byteenable;
    assign a_wd   = clearing ? '0 : s1_writedata;
    assign b_we   = wr2 & in2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] q1_q;
    logic [DATA_W-1:0] q2_q;

    // Port A is assigned last so s1 wins any byte both ports enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (b_we && s2_byteenable[i]) begin
                mem_q[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
            end
            if (a_we && a_be[i]) begin
                mem_q[a_addr][i*8 +: 8] <= a_wd[i*8 +: 8];
            end
        end
        if (rd1 && in1) begin
            q1_q <= mem_q[s1_address];
        end
        if (rd2 && in2) begin
            q2_q <= mem_q[s2_address];
        end
    end

    assign s1_waitrequest = busy;
    assign s2_waitrequest = busy;

    nios2_onchip_ram_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd1 (
        .clk             (clk),
        .reset           (reset),
        .rd_i            (rd1),
        .oor_i           (~in1),
        .ram_q_i         (q1_q),
        .readdata_o      (s1_readdata),
        .readdatavalid_o (s1_readdatavalid)
    );

    nios2_onchip_ram_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd2 (
        .clk             (clk),
        .reset           (reset),
        .rd_i            (rd2),
        .oor_i           (~in2),
        .ram_q_i         (q2_q),
        .readdata_o      (s2_readdata),
        .readdatavalid_o (s2_readdatavalid)
    );

endmodule

// File: tb/tb_nios2_onchip_ram_dp.sv
// Bench for nios2_onchip_ram_dp: one instance per read latency,
// directed table, corner sequences and a random scoreboard run.
module tb_nios2_onchip_ram_dp;

    localparam int DEPTH = 10;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [3:0]  s1_address = '0, s2_address = '0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic        s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic        s1_read = 1'b0, s2_read = 1'b0;
    logic        s1_write = 1'b0, s2_write = 1'b0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
    logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;
    logic        a_s1_w, a_s2_w, b_s1_w, b_s2_w;

    nios2_onchip_ram_dp #(
        .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) ua (
        .clk(clk), .reset(reset),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v),
        .s1_waitrequest(a_s1_w),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable),
        .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v),
        .s2_waitrequest(a_s2_w)
    );

    nios2_onchip_ram_dp #(
        .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) ub (
        .clk(clk), .reset(reset),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v),
        .s1_waitrequest(b_s1_w),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable),
        .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v),
        .s2_waitrequest(b_s2_w)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int clear_left = DEPTH;
    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    // Expected returns: 0/1 = lat-1 s1/s2, 2/3 = lat-2 s1/s2.
    exp_t q [4][$];
    int   vcnt [4] = '{0, 0, 0, 0};

    task automatic chk_eq(input string nm, input logic [31:0] got,
                          input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic push_rd(input int id, input logic [31:0] d,
                           input int due);
        exp_t e;
        e.d = d;
        e.due = due;
        q[id].push_back(e);
    endtask

    task automatic model_access();
        logic w1, w2, r1, r2;
        logic [31:0] o1, o2, m;
        w1 = s1_chipselect && s1_write;
        r1 = s1_chipselect && s1_read && !s1_write;
        w2 = s2_chipselect && s2_write;
        r2 = s2_chipselect && s2_read && !s2_write;
        o1 = (s1_address < DEPTH) ? mdl[s1_address] : 32'h0;
        o2 = (s2_address < DEPTH) ? mdl[s2_address] : 32'h0;
        if (r1) begin
            push_rd(0, o1, cyc);
            push_rd(2, o1, cyc + 1);
        end
        if (r2) begin
            push_rd(1, o2, cyc);
            push_rd(3, o2, cyc + 1);
        end
        // s2 first, then s1 on top: s1 owns the bytes it enables.
        if (w2 && s2_address < DEPTH) begin
            m = bemask(s2_byteenable);
            mdl[s2_address] = (mdl[s2_address] & ~m) | (s2_writedata & m);
        end
        if (w1 && s1_address < DEPTH) begin
            m = bemask(s1_byteenable);
            mdl[s1_address] = (mdl[s1_address] & ~m) | (s1_writedata & m);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
            for (int i = 0; i < 4; i++) q[i].delete();
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            model_access();
        end
    end

    task automatic chk_port(input int id, input logic v,
                            input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) vcnt[id]++;
        if (reset) begin
            chk_eq($sformatf("rdv_in_reset_p%0d", id), {31'b0, v}, 32'h0);
            q[id].delete();
        end else if (v === 1'b1) begin
            checks++;
            if (q[id].size() == 0) begin
                failures++;
                $display("FAIL spurious_rdv_p%0d got=1 want=0 cyc=%0d",
                         id, cyc);
            end else begin
                e = q[id].pop_front();
                if (d !== e.d || cyc != e.due) begin
                    failures++;
                    $display("FAIL rd_p%0d got=%h@%0d want=%h@%0d",
                             id, d, cyc, e.d, e.due);
                end
            end
        end else if (v !== 1'b0) begin
            chk_eq($sformatf("rdv_x_p%0d", id), {31'b0, v}, 32'h0);
        end else if (q[id].size() > 0 && q[id][0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_rdv_p%0d got=0 want=1 due=%0d",
                     id, q[id][0].due);
            void'(q[id].pop_front());
        end
    endtask

    logic wexp;
    always @(negedge clk) begin
        wexp = reset || (clear_left != 0);
        chk_eq("wait_a1", {31'b0, a_s1_w}, {31'b0, wexp});
        chk_eq("wait_a2", {31'b0, a_s2_w}, {31'b0, wexp});
        chk_eq("wait_b1", {31'b0, b_s1_w}, {31'b0, wexp});
        chk_eq("wait_b2", {31'b0, b_s2_w}, {31'b0, wexp});
        chk_port(0, a_s1_v, a_s1_rd);
        chk_port(1, a_s2_v, a_s2_rd);
        chk_port(2, b_s1_v, b_s1_rd);
        chk_port(3, b_s2_v, b_s2_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    endtask

    task automatic drive(input int port, input bit wr,
                         input logic [3:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        if (port == 1) begin
            s1_chipselect = 1'b1; s1_read = !wr; s1_write = wr;
            s1_address = addr; s1_byteenable = be; s1_writedata = wd;
        end else begin
            s2_chipselect = 1'b1; s2_read = !wr; s2_write = wr;
            s2_address = addr; s2_byteenable = be; s2_writedata = wd;
        end
    endtask

    task automatic expect_rd(input int port, input logic [31:0] exp,
                             input string nm);
        logic [31:0] ra, rb;
        bit ga, gb;
        ga = 0; gb = 0; ra = 'x; rb = 'x;
        repeat (4) begin
            @(negedge clk);
            if (!ga && (port == 1 ? a_s1_v : a_s2_v) === 1'b1) begin
                ga = 1; ra = (port == 1) ? a_s1_rd : a_s2_rd;
            end
            if (!gb && (port == 1 ? b_s1_v : b_s2_v) === 1'b1) begin
                gb = 1; rb = (port == 1) ? b_s1_rd : b_s2_rd;
            end
        end
        chk_eq({nm, "_lat1"}, ra, exp);
        chk_eq({nm, "_lat2"}, rb, exp);
    endtask

    task automatic rd_direct(input int port, input logic [3:0] addr,
                             input logic [31:0] exp, input string nm);
        idle();
        drive(port, 0, addr, 4'hF, 32'h0);
        tick();
        idle();
        expect_rd(port, exp, nm);
        tick();
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        repeat (3 * DEPTH) begin
            @(negedge clk);
            if (a_s1_w === 1'b1) n++;
        end
        chk_eq(nm, 32'(n), 32'(DEPTH));
        tick();
    endtask

    task automatic rand_port(input int port);
        int op;
        logic [3:0] addr;
        op = $urandom_range(0, 2);
        addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(4, 7));
        drive(port, op != 0, addr, 4'($urandom_range(0, 15)), $urandom);
        if (op == 2) begin
            if (port == 1) s1_read = 1'b1;
            else s2_read = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
            if (port == 1) s1_chipselect = 1'b0;
            else s2_chipselect = 1'b0;
        end
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t tv [NV];

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int v0, v1;
        tv[0]  = '{1, 1, 4'd3,  4'hF, 32'hDEADBEEF, 32'h0};
        tv[1]  = '{2, 0, 4'd3,  4'hF, 32'h0,        32'hDEADBEEF};
        tv[2]  = '{1, 1, 4'd4,  4'hF, 32'h11223344, 32'h0};
        tv[3]  = '{2, 1, 4'd4,  4'h5, 32'hAABBCCDD, 32'h0};
        tv[4]  = '{1, 0, 4'd4,  4'hF, 32'h0,        32'h11BB33DD};
        tv[5]  = '{1, 1, 4'd12, 4'hF, 32'h00000055, 32'h0};
        tv[6]  = '{2, 0, 4'd12, 4'hF, 32'h0,        32'h0};
        tv[7]  = '{2, 1, 4'd9,  4'hF, 32'h12345678, 32'h0};
        tv[8]  = '{1, 1, 4'd15, 4'hF, 32'hFFFFFFFF, 32'h0};
        tv[9]  = '{1, 0, 4'd9,  4'hF, 32'h0,        32'h12345678};
        tv[10] = '{2, 0, 4'd15, 4'hF, 32'h0,        32'h0};
        tv[11] = '{1, 0, 4'd0,  4'hF, 32'h0,        32'h0};
        tv[12] = '{2, 1, 4'd8,  4'h2, 32'hFFFFEEFF, 32'h0};
        tv[13] = '{1, 0, 4'd8,  4'hF, 32'h0,        32'h0000EE00};

        idle();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk_eq("reset_rd_a1", a_s1_rd, 32'h0);
        chk_eq("reset_rd_a2", a_s2_rd, 32'h0);
        chk_eq("reset_rd_b1", b_s1_rd, 32'h0);
        chk_eq("reset_rd_b2", b_s2_rd, 32'h0);
        tick();
        reset = 1'b0;
        wait_clear("clear_sweep");

        v0 = vcnt[1]; v1 = vcnt[3];
        for (int i = 0; i < DEPTH; i++) begin
            drive(2, 0, 4'(i), 4'hF, 32'h0);
            tick();
        end
        idle();
        repeat (4) tick();
        chk_eq("sweep_reads_lat1", 32'(vcnt[1] - v0), 32'(DEPTH));
        chk_eq("sweep_reads_lat2", 32'(vcnt[3] - v1), 32'(DEPTH));

        for (int i = 0; i < NV; i++) begin
            if (tv[i].wr) begin
                idle();
                drive(tv[i].port, 1, tv[i].addr, tv[i].be, tv[i].wd);
                tick();
                idle();
            end else begin
                rd_direct(tv[i].port, tv[i].addr, tv[i].exp,
                          $sformatf("vec%0d", i));
            end
        end

        v0 = vcnt[0]; v1 = vcnt[2];
        drive(1, 0, 4'd3, 4'hF, 32'h0);
        repeat (3) tick();
        idle();
        repeat (4) tick();
        chk_eq("b2b_strobes_lat1", 32'(vcnt[0] - v0), 32'd3);
        chk_eq("b2b_strobes_lat2", 32'(vcnt[2] - v1), 32'd3);

        drive(1, 1, 4'd5, 4'h1, 32'h000000AA);
        drive(2, 1, 4'd5, 4'hF, 32'hBBBBBBBB);
        tick();
        idle();
        drive(1, 1, 4'd5, 4'hF, 32'h01020304);
        drive(2, 0, 4'd5, 4'hF, 32'h0);
        tick();
        idle();
        expect_rd(2, 32'hBBBBBBAA, "collide_old");
        tick();
        rd_direct(1, 4'd5, 32'h01020304, "rdw_new");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear("clear_restart");
        rd_direct(1, 4'd3, 32'h0, "cleared_3");

        drive(1, 1, 4'd2, 4'hF, 32'hCAFEF00D);
        tick();
        idle();
        v0 = vcnt[0]; v1 = vcnt[2];
        drive(1, 0, 4'd2, 4'hF, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_eq("inflight_drop_lat1", 32'(vcnt[0] - v0), 32'd0);
        chk_eq("inflight_drop_lat2", 32'(vcnt[2] - v1), 32'd0);
        wait_clear("clear_after_inflight");

        for (int k = 0; k < 400; k++) begin
            rand_port(1);
            rand_port(2);
            tick();
        end
        idle();
        repeat (5) tick();

        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("q%0d_drained", i), 32'(q[i].size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
